// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
// Bundles the two write requesters (pipeline writeback and debug/loader),
// their grants, and the register-file write port driven by the arbiter.
//   master : requester side (drives requests, observes grants, rf, initBusy)
//   slave  : arbiter side   (observes requests, drives grants, rf, initBusy)
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if;
  logic        wbReq;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        wbGrant;
  logic        dbgReq;
  logic [4:0]  dbgAddr;
  logic [31:0] dbgData;
  logic        dbgGrant;
  logic        rfWrite;
  logic [4:0]  rfAddr;
  logic [31:0] rfData;
  logic        initBusy;

  modport master (
    output wbReq, wbAddr, wbData, dbgReq, dbgAddr, dbgData,
    input  wbGrant, dbgGrant, rfWrite, rfAddr, rfData, initBusy
  );

  modport slave (
    input  wbReq, wbAddr, wbData, dbgReq, dbgAddr, dbgData,
    output wbGrant, dbgGrant, rfWrite, rfAddr, rfData, initBusy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Arbitrates register-file writes between the pipeline writeback port and a
// debug/loader port, with an optional zero-fill sweep of all 32 registers
// after reset.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of regfile_write_arbiter_if
//           requests/addr/data in, grants out (combinational),
//           rfWrite/rfAddr/rfData out (registered, one cycle after transfer),
//           initBusy out (high while the zero-fill sweep runs)
// Parameters:
//   INIT_ON_RESET : 1 = zero-fill all registers after reset
//   STARVE_LIMIT  : consecutive wb grants tolerated while dbg waits (1..15)
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter bit          INIT_ON_RESET = 1'b1,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  regfile_write_arbiter_if.slave  bus
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam state_t     RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;
  localparam logic [3:0] LIMIT       = 4'(STARVE_LIMIT);

  state_t      state;
  logic [4:0]  sweep;
  logic [3:0]  starve;
  logic        wb_grant;
  logic        dbg_grant;
  logic        rf_write;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  // Grants are decided in the same cycle as the request. dbg wins when wb is
  // idle or when it has already been passed over LIMIT times in a row.
  // Gating with rst_n keeps the grants low while reset is held, even in the
  // configuration that comes out of reset directly in RUN.
  always_comb begin
    // NOTE: defaults first so no path leaves a grant unassigned (no latch).
    wb_grant  = 1'b0;
    dbg_grant = 1'b0;
    if (rst_n && state == ST_RUN) begin
      if (bus.dbgReq && (starve == LIMIT || !bus.wbReq)) begin
        dbg_grant = 1'b1;
      end else if (bus.wbReq) begin
        wb_grant = 1'b1;
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RESET_STATE;
      sweep    <= '0;
      starve   <= '0;
      rf_write <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
    end else begin
      // Starvation count: tracks wb grants that passed over a waiting dbg.
      if (dbg_grant || !bus.dbgReq) begin
        starve <= '0;
      end else if (wb_grant) begin
        starve <= starve + 4'd1;
      end

      case (state)
        ST_INIT: begin
          rf_write <= 1'b1;
          rf_addr  <= sweep;
          rf_data  <= '0;
          sweep    <= sweep + 5'd1;
          if (sweep == 5'd31) begin
            state <= ST_RUN;
          end
        end
        default: begin
          // r0 is hard-wired: the handshake completes but nothing is written.
          if (wb_grant) begin
            rf_write <= |bus.wbAddr;
            rf_addr  <= bus.wbAddr;
            rf_data  <= bus.wbData;
          end else if (dbg_grant) begin
            rf_write <= |bus.dbgAddr;
            rf_addr  <= bus.dbgAddr;
            rf_data  <= bus.dbgData;
          end else begin
            rf_write <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.wbGrant  = wb_grant;
  assign bus.dbgGrant = dbg_grant;
  assign bus.rfWrite  = rf_write;
  assign bus.rfAddr   = rf_addr;
  assign bus.rfData   = rf_data;
  assign bus.initBusy = (state == ST_INIT);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Two arbiters side by side: dut_a (zero-fill on, limit 4) and dut_b
// (zero-fill off, limit 2), driven with identical requests. A reference
// model tracks, per instance, how many sweep cycles remain, how many wb
// grants dbg has been passed over for, and the last rf write presented.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_write_arbiter_if ifa ();
  regfile_write_arbiter_if ifb ();

  regfile_write_arbiter #(.INIT_ON_RESET(1'b1), .STARVE_LIMIT(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  regfile_write_arbiter #(.INIT_ON_RESET(1'b0), .STARVE_LIMIT(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  // Shared requester stimulus.
  logic        wb_req,  dbg_req;
  logic [4:0]  wb_addr, dbg_addr;
  logic [31:0] wb_data, dbg_data;

  assign ifa.wbReq  = wb_req;   assign ifb.wbReq  = wb_req;
  assign ifa.wbAddr = wb_addr;  assign ifb.wbAddr = wb_addr;
  assign ifa.wbData = wb_data;  assign ifb.wbData = wb_data;
  assign ifa.dbgReq  = dbg_req;  assign ifb.dbgReq  = dbg_req;
  assign ifa.dbgAddr = dbg_addr; assign ifb.dbgAddr = dbg_addr;
  assign ifa.dbgData = dbg_data; assign ifb.dbgData = dbg_data;

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int          init_left [2];
  int          passed    [2];
  bit          m_wr      [2];
  logic [4:0]  m_addr    [2];
  logic [31:0] m_data    [2];
  bit          egw       [2];
  bit          egd       [2];
  bit          last_gw, last_gd;

  function automatic int limit_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic int sweep_len(input int k);
    return (k == 0) ? 32 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      init_left[k] = sweep_len(k);
      passed[k]    = 0;
      m_wr[k]      = 1'b0;
      m_addr[k]    = '0;
      m_data[k]    = '0;
    end
    last_gw = 1'b0;
    last_gd = 1'b0;
  endtask

  // Who should win this cycle, from the arbitration rules.
  task automatic model_grants();
    for (int k = 0; k < 2; k++) begin
      egw[k] = 1'b0;
      egd[k] = 1'b0;
      if (init_left[k] == 0) begin
        if (dbg_req && (passed[k] >= limit_of(k) || !wb_req)) egd[k] = 1'b1;
        else if (wb_req)                                       egw[k] = 1'b1;
      end
    end
  endtask

  // What the rf port should show after the coming edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!dbg_req || egd[k]) passed[k] = 0;
      else if (egw[k])        passed[k] = passed[k] + 1;
      if (init_left[k] > 0) begin
        m_wr[k]   = 1'b1;
        m_addr[k] = 5'(sweep_len(k) - init_left[k]);
        m_data[k] = '0;
        init_left[k] = init_left[k] - 1;
      end else if (egw[k]) begin
        m_wr[k] = (wb_addr != 0);  m_addr[k] = wb_addr;  m_data[k] = wb_data;
      end else if (egd[k]) begin
        m_wr[k] = (dbg_addr != 0); m_addr[k] = dbg_addr; m_data[k] = dbg_data;
      end else begin
        m_wr[k] = 1'b0;
      end
    end
  endtask

  task automatic check_rf();
    chk("a.rfWrite",  ifa.rfWrite,  m_wr[0]);
    chk("a.rfAddr",   ifa.rfAddr,   m_addr[0]);
    chk("a.rfData",   ifa.rfData,   m_data[0]);
    chk("a.initBusy", ifa.initBusy, init_left[0] > 0);
    chk("b.rfWrite",  ifb.rfWrite,  m_wr[1]);
    chk("b.rfAddr",   ifb.rfAddr,   m_addr[1]);
    chk("b.rfData",   ifb.rfData,   m_data[1]);
    chk("b.initBusy", ifb.initBusy, 1'b0);
  endtask

  // One clock cycle: called at a negedge; drives inputs, checks grants,
  // crosses the posedge, updates the model, checks rf at the next negedge.
  task automatic cycle(input bit wr, input logic [4:0] wa, input logic [31:0] wd,
                       input bit dr, input logic [4:0] da, input logic [31:0] dd);
    wb_req = wr;  wb_addr = wa;  wb_data = wd;
    dbg_req = dr; dbg_addr = da; dbg_data = dd;
    #1;
    model_grants();
    chk("a.wbGrant",  ifa.wbGrant,  egw[0]);
    chk("a.dbgGrant", ifa.dbgGrant, egd[0]);
    chk("b.wbGrant",  ifb.wbGrant,  egw[1]);
    chk("b.dbgGrant", ifb.dbgGrant, egd[1]);
    last_gw = egw[0];
    last_gd = egd[0];
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_rf();
  endtask

  // Assert reset mid-cycle with requests active and verify the immediate clear.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.a.rfWrite",  ifa.rfWrite,  1'b0);
    chk("rst.a.rfAddr",   ifa.rfAddr,   5'd0);
    chk("rst.a.rfData",   ifa.rfData,   32'd0);
    chk("rst.a.wbGrant",  ifa.wbGrant,  1'b0);
    chk("rst.a.dbgGrant", ifa.dbgGrant, 1'b0);
    chk("rst.a.initBusy", ifa.initBusy, 1'b1);
    chk("rst.b.rfWrite",  ifb.rfWrite,  1'b0);
    chk("rst.b.rfAddr",   ifb.rfAddr,   5'd0);
    chk("rst.b.wbGrant",  ifb.wbGrant,  1'b0);
    chk("rst.b.dbgGrant", ifb.dbgGrant, 1'b0);
    chk("rst.b.initBusy", ifb.initBusy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b1;
    wb_req   = 1'b1; wb_addr  = 5'd7; wb_data  = 32'hCAFE_0007;
    dbg_req  = 1'b0; dbg_addr = 5'd0; dbg_data = 32'd0;
    model_reset();
    @(negedge clk);

    // Reset with wbReq held, then the full sweep; dut_b grants immediately.
    pulse_reset();
    repeat (34) cycle(1'b1, 5'd7, 32'hCAFE_0007, 1'b0, 5'd0, 32'd0);

    // Single wb write, dbg idle.
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Both requesting continuously: wb x4 then dbg on dut_a, wb x2 then dbg on dut_b.
    repeat (12) cycle(1'b1, 5'd9, 32'h0000_0909, 1'b1, 5'd12, 32'h0000_1212);

    // dbg write to r0 is acknowledged but not written.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_1234);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Reset mid-sweep at address 17, then the sweep restarts from 0.
    pulse_reset();
    repeat (18) cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_0303);
    chk("sweep_at_17", ifa.rfAddr, 5'd17);
    pulse_reset();
    repeat (34) cycle(1'b1, 5'd4, 32'h0000_0404, 1'b0, 5'd0, 32'd0);

    // Randomized traffic; a requester holds addr/data until granted.
    for (int n = 0; n < 400; n++) begin
      bit          wr, dr;
      logic [4:0]  wa, da;
      logic [31:0] wd, dd;
      wr = wb_req;  wa = wb_addr;  wd = wb_data;
      dr = dbg_req; da = dbg_addr; dd = dbg_data;
      if (!(wr && !last_gw)) begin
        wr = ($urandom_range(0, 3) != 0);
        wa = 5'($urandom_range(0, 31));
        wd = $urandom;
      end
      if (!(dr && !last_gd)) begin
        dr = ($urandom_range(0, 2) != 0);
        da = 5'($urandom_range(0, 31));
        dd = $urandom;
      end
      cycle(wr, wa, wd, dr, da, dd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter INIT_ON_RESET, default 1: when 1, the block zero-fills all 32 registers after reset.
REQ-002 Parameter STARVE_LIMIT, default 4: maximum number of consecutive wb grants while dbgReq is pending (legal range 1..15).
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 wbReq  input  1  pipeline writeback write request.
REQ-006 wbAddr  input  5  writeback destination register.
REQ-007 wbData  input  32  writeback data.
REQ-008 wbGrant  output  1  writeback request accepted this cycle.
REQ-009 dbgReq  input  1  debug/loader write request.
REQ-010 dbgAddr  input  5  debug destination register.
REQ-011 dbgData  input  32  debug data.
REQ-012 dbgGrant  output  1  debug request accepted this cycle.
REQ-013 rfWrite  output  1  register-file write enable.
REQ-014 rfAddr  output  5  register-file write address.
REQ-015 rfData  output  32  register-file write data.
REQ-016 initBusy  output  1  zero-fill sweep in progress.

Function
REQ-017 FSM states: INIT and RUN; after reset the FSM enters INIT if INIT_ON_RESET=1, otherwise RUN.
REQ-018 INIT: 5-bit sweep counter starts at 0; each cycle the registered outputs present rfWrite=1, rfAddr=counter, rfData=0; the counter increments once per cycle.
REQ-019 INIT -> RUN on the cycle after the write to address 31, i.e. exactly 32 write cycles; initBusy=1 throughout INIT, 0 in RUN.
REQ-020 In INIT, wbGrant=dbgGrant=0 regardless of requests; requests are held by the requesters, not dropped.
REQ-021 Handshake: a grant is combinational from the current requests and state; a transfer occurs on the clock edge where req&&grant=1; the requester holds addr/data stable until granted.
REQ-022 RUN priority: wb wins over dbg by default; at most one grant per cycle; grants are 0 when the corresponding request is 0.
REQ-023 Starvation counter (4 bits): increments on every cycle where wbGrant=1 and dbgReq=1; clears on any dbgGrant or when dbgReq=0.
REQ-024 When the starvation counter equals STARVE_LIMIT and dbgReq=1, dbg is granted that cycle even if wbReq=1, and wbGrant=0.
REQ-025 Write latency: a transfer at edge N drives rfWrite/rfAddr/rfData during the cycle after edge N (one registered stage); rfAddr and rfData carry the granted requester's values.
REQ-026 Address 0: a granted request with addr=0 completes the handshake normally, but rfWrite stays 0 for that transfer (r0 is never written).
REQ-027 No transfer in a RUN cycle -> rfWrite=0 next cycle; rfAddr and rfData hold their previous values.
REQ-028 Back-to-back transfers are allowed every cycle, so sustained throughput is one write per cycle.

Reset
REQ-029 While rst_n=0, immediately: rfWrite=0, rfAddr=0, rfData=0, wbGrant=0, dbgGrant=0; sweep and starvation counters=0.
REQ-030 While rst_n=0, initBusy=1 if INIT_ON_RESET=1, else 0.
REQ-031 Reset asserted mid-INIT or mid-RUN aborts the operation; any in-flight registered write is dropped, and the sweep restarts from address 0 after release.

Verification
REQ-032 Reset release with INIT_ON_RESET=1, wbReq=1 held -> 32 cycles of rfWrite=1 at rfAddr 0..31 with rfData=0 and wbGrant=0; first wbGrant on cycle 33.
REQ-033 RUN: wbReq=1, addr=5, data=0xDEADBEEF and dbgReq=0 -> wbGrant=1 the same cycle; next cycle rfWrite=1, rfAddr=5, rfData=0xDEADBEEF.
REQ-034 RUN: wbReq and dbgReq held at 1, STARVE_LIMIT=4 -> grant sequence wb,wb,wb,wb,dbg repeating; rf outputs follow one cycle later.
REQ-035 RUN: dbgReq=1 with addr=0, data=0x1234 -> dbgGrant=1, and rfWrite=0 on the following cycle.
REQ-036 rst_n pulsed low at sweep address 17 -> outputs clear immediately; after release the sweep restarts at address 0 and runs all 32 cycles.
REQ-037 INIT_ON_RESET=0, reset release with wbReq=1 -> wbGrant=1 in the first cycle after release and initBusy=0 throughout.
